// File: rtl/count_ctrl_if.sv
// Bus between count_ctrl and the COUNT evaluator / run controller.
// master is the count_ctrl side, slave is the neighbouring logic.
interface count_ctrl_if;
   logic       start;
   logic       stop;
   logic       clear;
   logic [7:0] count_nxt;
   logic       A;
   logic       B;
   logic       C;
   logic [1:0] state;
   logic [7:0] count_q;
   logic       done;

   modport master (
      input  start, stop, clear, count_nxt,
      output A, B, C, state, count_q, done
   );

   modport slave (
      output start, stop, clear, count_nxt,
      input  A, B, C, state, count_q, done
   );
endinterface

// File: rtl/count_ctrl.sv
// Event synchronisers, run-state sequencer and count register in front of
// the combinational COUNT evaluator.
module count_ctrl #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] LIMIT       = 8'd255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         a_raw,
   input  logic         b_raw,
   input  logic         c_raw,
   count_ctrl_if.master bus
);
   localparam int DW = $clog2(SYNC_STAGES + 2);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10,
      DONE  = 2'b11
   } state_t;

   logic [2:0]                  raw;
   logic [2:0][SYNC_STAGES-1:0] sync;
   logic [2:0]                  hist;
   logic [2:0]                  pulse;

   state_t        st;
   logic [DW-1:0] drain;
   logic [7:0]    cnt;
   logic          done_r;

   assign raw = {c_raw, b_raw, a_raw};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '0;
         hist  <= '0;
         pulse <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            sync[i]  <= {sync[i][SYNC_STAGES-2:0], raw[i]};
            hist[i]  <= sync[i][SYNC_STAGES-1];
            pulse[i] <= sync[i][SYNC_STAGES-1] & ~hist[i];
         end
      end
   end

   // Drain covers the pulses still inside the synchroniser when stop lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= IDLE;
         drain  <= '0;
         cnt    <= '0;
         done_r <= 1'b0;
      end else begin
         cnt <= bus.clear ? 8'd0 : bus.count_nxt;
         if (bus.clear) begin
            st     <= IDLE;
            drain  <= '0;
            done_r <= 1'b0;
         end else begin
            case (st)
               IDLE: if (bus.start) st <= RUN;
               RUN: begin
                  if (bus.count_nxt == LIMIT) begin
                     st     <= DONE;
                     done_r <= 1'b1;
                  end else if (bus.stop) begin
                     st    <= DRAIN;
                     drain <= DW'(SYNC_STAGES + 1);
                  end
               end
               DRAIN: begin
                  drain <= drain - DW'(1);
                  if (bus.count_nxt == LIMIT || drain == DW'(1)) begin
                     st     <= DONE;
                     done_r <= 1'b1;
                  end
               end
               DONE: st <= DONE;
               default: st <= IDLE;
            endcase
         end
      end
   end

   assign bus.A       = pulse[0];
   assign bus.B       = pulse[1];
   assign bus.C       = pulse[2];
   assign bus.state   = st;
   assign bus.count_q = cnt;
   assign bus.done    = done_r;
endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: cycle tables plus hand sequences, with a
// tiny COUNT stand-in that adds one per cycle when any pulse is high in 01/10.
module tb_count_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_raw = 1'b0, b_raw = 1'b0, c_raw = 1'b0;
   int   tests = 0;
   int   fails = 0;

   count_ctrl_if bus ();

   count_ctrl #(.SYNC_STAGES(2), .LIMIT(8'd5)) dut (
      .clk   (clk),
      .rst   (rst),
      .a_raw (a_raw),
      .b_raw (b_raw),
      .c_raw (c_raw),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always_comb begin
      bus.count_nxt = bus.count_q;
      if ((bus.state == 2'b01 || bus.state == 2'b10) && (bus.A | bus.B | bus.C))
         bus.count_nxt = bus.count_q + 8'd1;
   end

   typedef struct {
      logic       rst, a, b, c, start, stop, clear;
      logic       ea, eb, ec;
      logic [1:0] est;
      logic [7:0] ecnt;
      logic       edone;
   } vec_t;

   vec_t tv[$];

   task automatic vec(input logic r, a, b, c, s, p, cl,
                      input logic ea, eb, ec, input logic [1:0] est,
                      input logic [7:0] ecnt, input logic edone);
      vec_t v;
      v.rst = r; v.a = a; v.b = b; v.c = c; v.start = s; v.stop = p; v.clear = cl;
      v.ea = ea; v.eb = eb; v.ec = ec; v.est = est; v.ecnt = ecnt; v.edone = edone;
      tv.push_back(v);
   endtask

   task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
      end
   endtask

   task automatic apply(input int idx);
      vec_t v;
      v = tv[idx];
      rst = v.rst; a_raw = v.a; b_raw = v.b; c_raw = v.c;
      bus.start = v.start; bus.stop = v.stop; bus.clear = v.clear;
      @(posedge clk); #1;
      chk("A", idx, 8'(bus.A), 8'(v.ea));
      chk("B", idx, 8'(bus.B), 8'(v.eb));
      chk("C", idx, 8'(bus.C), 8'(v.ec));
      chk("state", idx, 8'(bus.state), 8'(v.est));
      chk("count_q", idx, bus.count_q, v.ecnt);
      chk("done", idx, 8'(bus.done), 8'(v.edone));
   endtask

   task automatic step(input logic a, s, p, cl);
      rst = 1'b0; a_raw = a; b_raw = 1'b0; c_raw = 1'b0;
      bus.start = s; bus.stop = p; bus.clear = cl;
      @(posedge clk); #1;
   endtask

   initial begin
      int pulses;
      bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;

      // reset with a_raw high, then a run of three counted rises (last one on A/B/C together)
      //  rst a b c st sp cl   A B C  state cnt done
      vec(1, 1,0,0, 0,0,0,  0,0,0, 2'd0, 8'd0, 0);
      vec(1, 1,0,0, 0,0,0,  0,0,0, 2'd0, 8'd0, 0);
      vec(1, 1,0,0, 0,0,0,  0,0,0, 2'd0, 8'd0, 0);
      vec(0, 1,0,0, 0,0,0,  0,0,0, 2'd0, 8'd0, 0);
      vec(0, 1,0,0, 0,0,0,  0,0,0, 2'd0, 8'd0, 0);
      vec(0, 1,0,0, 0,0,0,  1,0,0, 2'd0, 8'd0, 0);
      vec(0, 1,0,0, 0,0,0,  0,0,0, 2'd0, 8'd0, 0);
      vec(0, 0,0,0, 0,0,0,  0,0,0, 2'd0, 8'd0, 0);
      vec(0, 0,0,0, 1,0,0,  0,0,0, 2'd1, 8'd0, 0);
      vec(0, 1,0,0, 0,0,0,  0,0,0, 2'd1, 8'd0, 0);
      vec(0, 0,0,0, 0,0,0,  0,0,0, 2'd1, 8'd0, 0);
      vec(0, 0,0,0, 0,0,0,  1,0,0, 2'd1, 8'd0, 0);
      vec(0, 0,0,0, 0,0,0,  0,0,0, 2'd1, 8'd1, 0);
      vec(0, 1,0,0, 0,0,0,  0,0,0, 2'd1, 8'd1, 0);
      vec(0, 0,0,0, 0,0,0,  0,0,0, 2'd1, 8'd1, 0);
      vec(0, 0,0,0, 0,0,0,  1,0,0, 2'd1, 8'd1, 0);
      vec(0, 0,0,0, 0,0,0,  0,0,0, 2'd1, 8'd2, 0);
      vec(0, 1,1,1, 0,0,0,  0,0,0, 2'd1, 8'd2, 0);
      vec(0, 0,0,0, 0,0,0,  0,0,0, 2'd1, 8'd2, 0);
      vec(0, 0,0,0, 0,0,0,  1,1,1, 2'd1, 8'd2, 0);
      vec(0, 0,0,0, 0,0,0,  0,0,0, 2'd1, 8'd3, 0);
      // clear-beats-start segment, entered from DONE
      vec(0, 0,0,0, 0,0,1,  0,0,0, 2'd0, 8'd0, 0);
      vec(0, 0,0,0, 1,0,0,  0,0,0, 2'd1, 8'd0, 0);
      vec(0, 1,0,0, 0,0,0,  0,0,0, 2'd1, 8'd0, 0);
      vec(0, 0,0,0, 0,0,0,  0,0,0, 2'd1, 8'd0, 0);
      vec(0, 0,0,0, 0,0,0,  1,0,0, 2'd1, 8'd0, 0);
      vec(0, 0,0,0, 0,0,0,  0,0,0, 2'd1, 8'd1, 0);
      vec(0, 1,0,0, 0,0,0,  0,0,0, 2'd1, 8'd1, 0);
      vec(0, 0,0,0, 0,0,0,  0,0,0, 2'd1, 8'd1, 0);
      vec(0, 0,0,0, 0,0,0,  1,0,0, 2'd1, 8'd1, 0);
      vec(0, 0,0,0, 0,0,0,  0,0,0, 2'd1, 8'd2, 0);
      vec(0, 0,0,0, 1,0,1,  0,0,0, 2'd0, 8'd0, 0);
      vec(0, 0,0,0, 1,0,0,  0,0,0, 2'd1, 8'd0, 0);

      for (int i = 0; i <= 20; i++) apply(i);

      // held-high input yields one pulse and one increment
      pulses = 0;
      for (int i = 0; i < 24; i++) begin
         step(i < 20, 1'b0, 1'b0, 1'b0);
         if (bus.A) pulses++;
      end
      chk("held_pulses", 0, 8'(pulses), 8'd1);
      chk("held_count", 0, bus.count_q, 8'd4);
      chk("held_state", 0, 8'(bus.state), 8'd1);

      // clear to IDLE, stop there is ignored, start re-enters RUN
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("clr_state", 0, 8'(bus.state), 8'd0);
      chk("clr_count", 0, bus.count_q, 8'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("idle_stop", 0, 8'(bus.state), 8'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("start_run", 0, 8'(bus.state), 8'd1);

      // rise one cycle before stop is still counted during drain
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("pre_stop", 0, 8'(bus.state), 8'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("drain1", 0, 8'(bus.state), 8'd2);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("drain2", 0, 8'(bus.state), 8'd2);
      chk("drain_A", 0, 8'(bus.A), 8'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("drain3", 0, 8'(bus.state), 8'd2);
      chk("drain_cnt", 0, bus.count_q, 8'd1);
      chk("drain_done0", 0, 8'(bus.done), 8'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("done_state", 0, 8'(bus.state), 8'd3);
      chk("done_flag", 0, 8'(bus.done), 8'd1);
      chk("done_cnt", 0, bus.count_q, 8'd1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("done_hold", 0, 8'(bus.state), 8'd3);
      chk("done_hold_flag", 0, 8'(bus.done), 8'd1);

      // terminal count at LIMIT=5
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t_clr", 0, 8'(bus.state), 8'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t_start", 0, 8'(bus.state), 8'd1);
      for (int k = 1; k <= 6; k++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
         chk("t_pre_cnt", k, bus.count_q, (k <= 5) ? 8'(k - 1) : 8'd5);
         chk("t_pre_state", k, 8'(bus.state), (k <= 5) ? 8'd1 : 8'd3);
         step(1'b0, 1'b0, 1'b0, 1'b0);
         chk("t_cnt", k, bus.count_q, (k <= 5) ? 8'(k) : 8'd5);
         chk("t_state", k, 8'(bus.state), (k >= 5) ? 8'd3 : 8'd1);
         chk("t_done", k, 8'(bus.done), (k >= 5) ? 8'd1 : 8'd0);
      end

      for (int i = 21; i < tv.size(); i++) apply(i);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
